// File: rtl/sw_debounce.sv
// Switch conditioner: per-channel synchroniser and stability-counter debounce,
// with a clean level output plus one-cycle rise/fall/changed event pulses.
module sw_debounce #(
    parameter int unsigned SW_NUM          = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [SW_NUM-1:0] sw_raw,
    output logic [SW_NUM-1:0] sw_db,
    output logic [SW_NUM-1:0] sw_rise,
    output logic [SW_NUM-1:0] sw_fall,
    output logic              sw_changed
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE,
        ST_COUNTING
    } state_t;

    logic [SW_NUM-1:0] sync_q [SYNC_STAGES];
    logic [SW_NUM-1:0] s;

    state_t            state_q [SW_NUM];
    state_t            state_d [SW_NUM];
    logic [CNT_W-1:0]  cnt_q   [SW_NUM];
    logic [CNT_W-1:0]  cnt_d   [SW_NUM];
    logic [SW_NUM-1:0] db_d;
    logic [SW_NUM-1:0] rise_d;
    logic [SW_NUM-1:0] fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Metastability synchroniser chain, one flop column per stage.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= sw_raw;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-channel state, counter and registered outputs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int unsigned i = 0; i < SW_NUM; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            sw_db      <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            sw_changed <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SW_NUM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            sw_db      <= db_d;
            sw_rise    <= rise_d;
            sw_fall    <= fall_d;
            sw_changed <= |(rise_d | fall_d);
        end
    end

    // Next-state: a channel commits once the synchronised level has differed
    // from the output for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = sw_db;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned i = 0; i < SW_NUM; i++) begin
            case (state_q[i])
                ST_STABLE: begin
                    cnt_d[i] = '0;
                    if (s[i] != sw_db[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            db_d[i]   = s[i];
                            rise_d[i] = s[i];
                            fall_d[i] = ~s[i];
                        end else begin
                            state_d[i] = ST_COUNTING;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                end
                ST_COUNTING: begin
                    if (s[i] == sw_db[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                        db_d[i]    = s[i];
                        rise_d[i]  = s[i];
                        fall_d[i]  = ~s[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: a sliding-window reference model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_sw_debounce;

    localparam int unsigned N = 3;
    localparam int unsigned S = 2;
    localparam int unsigned D = 8;

    typedef struct packed {
        logic [N-1:0] db;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         chg;
    } exp_t;

    logic         clk;
    logic         resetn;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_db;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic         sw_changed;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t         exp_q[$];
    logic [N-1:0] smp[$];
    logic [N-1:0] m_db;

    sw_debounce #(
        .SW_NUM         (N),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sw_raw    (sw_raw),
        .sw_db     (sw_db),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a bit flips on an edge when the level seen through the
    // S-edge synchroniser delay has differed from the output for the last D edges.
    always @(posedge clk) begin
        exp_t e;
        int   base;
        bit   all_diff;
        e = '0;
        if (resetn) begin
            smp.delete();
            for (int k = 0; k < int'(S + D); k++) smp.push_back('0);
            m_db = '0;
        end else begin
            smp.push_back(sw_raw);
            if (smp.size() > int'(S + D + 4)) void'(smp.pop_front());
            base = smp.size() - 1 - int'(S);
            for (int b = 0; b < int'(N); b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < int'(D); j++) begin
                    if (smp[base-j][b] == m_db[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_db[b]   = ~m_db[b];
                    e.rise[b] = m_db[b];
                    e.fall[b] = ~m_db[b];
                end
            end
            e.db  = m_db;
            e.chg = |(e.rise | e.fall);
        end
        exp_q.push_back(e);
    end

    // Monitor: one expected record per clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sw_db",      32'(sw_db),      32'(e.db));
            chk("sw_rise",    32'(sw_rise),    32'(e.rise));
            chk("sw_fall",    32'(sw_fall),    32'(e.fall));
            chk("sw_changed", 32'(sw_changed), 32'(e.chg));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new raw value and count edges until sw_db reaches it.
    task automatic drive_and_time(input logic [N-1:0] v, input string name);
        int k;
        @(negedge clk);
        sw_raw = v;
        k = 1;
        while (k <= 40) begin
            @(posedge clk);
            #1;
            if (sw_db == v) break;
            k++;
        end
        chk(name, 32'(k), 32'(S + D));
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 32'({sw_db, sw_rise, sw_fall, sw_changed}), 32'd0);
    endtask

    initial begin
        resetn = 1'b1;
        sw_raw = '0;
        #2;
        check_all_zero("reset_outputs");
        cyc(3);
        resetn = 1'b0;

        // Clean press with edge-accurate latency.
        cyc(5);
        drive_and_time(3'b001, "press_latency");
        cyc(10);

        // Glitch on bit1 shorter than the debounce window.
        sw_raw = 3'b011;
        cyc(5);
        sw_raw = 3'b001;
        cyc(20);

        // Bit2 bounces every 3 cycles, then settles high.
        for (int t = 0; t < 8; t++) begin
            sw_raw[2] = ~sw_raw[2];
            cyc(3);
        end
        drive_and_time(3'b101, "bounce_latency");
        cyc(10);

        // Walk: paired rise/fall commits on the same edge.
        sw_raw = 3'b001;
        cyc(20);
        sw_raw = 3'b010;
        cyc(20);
        sw_raw = 3'b100;
        cyc(20);

        // Simultaneous change on all bits.
        sw_raw = 3'b000;
        cyc(20);
        drive_and_time(3'b111, "simul_latency");
        cyc(10);

        // Async reset mid-count, with sw_db non-zero beforehand.
        sw_raw = 3'b110;
        cyc(20);
        sw_raw = 3'b001;
        cyc(7);
        #2;
        resetn = 1'b1;
        #1;
        check_all_zero("async_reset");
        cyc(2);
        resetn = 1'b0;
        sw_raw = 3'b000;
        drive_and_time(3'b001, "post_reset_latency");
        cyc(10);

        // Randomised per-bit hold lengths around the debounce window.
        for (int t = 0; t < 60; t++) begin
            sw_raw = N'($urandom_range(0, (1 << N) - 1));
            cyc(int'($urandom_range(1, 14)));
        end
        cyc(25);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Switch conditioning stage that sits directly upstream of the LED/switch controller and drives its sw input.
- Synchronises each raw board switch into the clk domain.
- Filters contact bounce with a per-channel stability counter.
- Outputs a clean level plus one-cycle rise/fall event pulses per switch.

Parameters:
SW_NUM, 3, number of switch channels
SYNC_STAGES, 2, synchroniser flop depth per channel (legal range: 2 or more)
DEBOUNCE_CYCLES, 8, consecutive stable cycles required before the output level changes (legal range: 1 or more; board build uses 1_000_000)

Ports:
clk  input  1  system clock
resetn  input  1  reset; asynchronous, active-high
sw_raw  input  SW_NUM  raw asynchronous switch levels
sw_db  output  SW_NUM  debounced switch level; feeds the LED controller sw input
sw_rise  output  SW_NUM  one-cycle pulse when the sw_db bit goes 0->1
sw_fall  output  SW_NUM  one-cycle pulse when the sw_db bit goes 1->0
sw_changed  output  1  OR-reduction of (sw_rise | sw_fall), registered, same cycle as the pulses

Behaviour:
Reset:
- resetn=1 immediately clears all synchroniser flops, counters, sw_db, sw_rise, sw_fall and sw_changed to 0, independent of clk.
- State is held at 0 while resetn=1.

Synchroniser:
- SYNC_STAGES-deep flop chain per bit. Its output s[i] reflects sw_raw[i] SYNC_STAGES clk edges after sampling.

Per-channel FSM (fully independent per bit i):
- STABLE: s[i]==sw_db[i]; counter cnt[i] held at 0.
  - If s[i]!=sw_db[i], go to COUNTING with cnt[i] <= 1.
- COUNTING, evaluated each edge:
  - If s[i]==sw_db[i]: bounce. cnt[i] <= 0, go to STABLE, no output change.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: sw_db[i] <= s[i], cnt[i] <= 0, go to STABLE, and on the same edge assert the matching sw_rise[i] or sw_fall[i] for exactly one cycle.
  - Else: cnt[i] <= cnt[i]+1.
- DEBOUNCE_CYCLES=1: sw_db[i] updates on the edge after s[i] differs; no COUNTING dwell.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never wraps, because it is cleared on commit or on a mismatch.

Latency:
- A clean raw transition appears on sw_db exactly SYNC_STAGES+DEBOUNCE_CYCLES clk edges after the first sampling edge that sees the new level.
- Any excursion of s[i] shorter than DEBOUNCE_CYCLES cycles produces no output change and no pulse.

Pulses and events:
- sw_rise and sw_fall are never both high on the same bit.
- Multiple bits may pulse in the same cycle. sw_changed is high for one cycle in that case, not one cycle per bit.
- Simultaneous raw changes on different bits are debounced independently and commit on the same edge if their timing matches.

Reset mid-operation:
- Any partial count is discarded.
- After release, a held-high raw input needs the full SYNC_STAGES+DEBOUNCE_CYCLES edges and then produces a sw_rise pulse, since sw_db restarts at 0.

Test Plan:
Test bench configuration for all scenarios: SW_NUM=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, clk period 10 ns.
1. Clean press: reset, then sw_raw=000 for 5 cycles, then 001 held. Required: sw_db=001 exactly 10 edges after the first edge sampling 001; sw_rise=001 and sw_changed=1 for one cycle on that edge; sw_fall=000 throughout.
2. Glitch reject: sw_db=000, sw_raw bit1 high for 5 cycles, then low. Required: sw_db stays 000; no rise, fall or changed pulse.
3. Bounce: sw_raw bit2 toggles every 3 cycles for 24 cycles, then holds 1. Required: a single sw_rise=100 exactly 10 edges after the final 0->1 raw edge, and no earlier pulses.
4. Walk and release (LED-controller stimulus order): sw_raw 001 -> 010 -> 100, each held 20 cycles. Required at each step: sw_db follows after 10 edges. Both changing bits commit on the same edge, so e.g. sw_rise=010 and sw_fall=001 appear together, with sw_changed a single one-cycle pulse.
5. Simultaneous: sw_raw 000 -> 111 on one edge. Required: sw_db=111 after 10 edges; sw_rise=111 for one cycle; sw_changed one-cycle pulse.
6. Async reset mid-count: sw_raw=001 held, assert resetn=1 for 2 cycles after 5 counted cycles. Required: all outputs 0 immediately, without waiting for clk. After release, sw_db=001 only 10 edges later, accompanied by sw_rise=001.
